fc_bn_res_relu_pipe: RTL and testbench



---
 rtl/fc_bn_res_relu_pipe_if.sv | 28 ++
 rtl/fc_bn_res_relu_pipe.sv | 221 ++++++++++++++++++++++
 tb/tb_fc_bn_res_relu_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_bn_res_relu_pipe_if.sv
// Streaming bus for fc_bn_res_relu_pipe: an input beat of FC results and
// residuals, and an output beat of finished results, each with valid/ready.
//   in_valid/in_ready : input handshake (master drives valid, slave ready)
//   in_dat / in_res   : TOUT channels of DAT_DW signed data / residual
//   out_valid/out_ready: output handshake (slave drives valid, master ready)
//   out_dat           : TOUT channels of DAT_DW signed results
interface fc_bn_res_relu_pipe_if #(
  parameter int TOUT   = 32,
  parameter int DAT_DW = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [TOUT*DAT_DW-1:0]   in_dat;
  logic [TOUT*DAT_DW-1:0]   in_res;
  logic                     out_valid;
  logic                     out_ready;
  logic [TOUT*DAT_DW-1:0]   out_dat;

  modport master (
    output in_valid, in_dat, in_res, out_ready,
    input  in_ready, out_valid, out_dat
  );

  modport slave (
    input  in_valid, in_dat, in_res, out_ready,
    output in_ready, out_valid, out_dat
  );
endinterface

// File: rtl/fc_bn_res_relu_pipe.sv
// FC post-processing pipeline: per-channel batch-norm scale/bias, optional
// residual add, rounding right shift, optional ReLU and saturation.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : one-cycle pulse in IDLE, latches all cfg_* inputs
//   cfg_pix, cfg_grp    : beats per channel group, number of channel groups
//   cfg_*_en, cfg_*_sh  : mode enables and shift amounts
//   prm_we/addr/wdata   : BN table write port ({bias,weight} per channel)
//   bus (slave)         : input/output streaming handshakes
//   busy, done, prm_err : job active, job-complete pulse, sticky bad-write flag
module fc_bn_res_relu_pipe #(
  parameter int TOUT    = 32,
  parameter int DAT_DW  = 16,
  parameter int BN_DW   = 16,
  parameter int MAX_GRP = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  cfg_pix,
  input  logic [$clog2(MAX_GRP):0]     cfg_grp,
  input  logic                         cfg_bn_en,
  input  logic                         cfg_res_en,
  input  logic                         cfg_relu_en,
  input  logic [4:0]                   cfg_bias_sh,
  input  logic [4:0]                   cfg_res_sh,
  input  logic [4:0]                   cfg_out_sh,
  input  logic                         prm_we,
  input  logic [$clog2(MAX_GRP)-1:0]   prm_addr,
  input  logic [TOUT*2*BN_DW-1:0]      prm_wdata,
  fc_bn_res_relu_pipe_if.slave         bus,
  output logic                         busy,
  output logic                         done,
  output logic                         prm_err
);

  localparam int GW = $clog2(MAX_GRP) + 1;
  localparam int AW = GW - 1;
  localparam int SW = DAT_DW + BN_DW + 34;
  localparam int TW = 16 + GW;
  localparam int PW = TOUT * 2 * BN_DW;
  localparam int DW = TOUT * DAT_DW;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DAT_DW+1){1'b0}}, {(DAT_DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DAT_DW+1){1'b1}}, {(DAT_DW-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;

  // latched job configuration
  logic [15:0]   pix_r;
  logic [GW-1:0] grp_r;
  logic [TW-1:0] total_r;
  logic          bn_r, res_r, relu_r;
  logic [4:0]    bsh_r, rsh_r, osh_r;

  // input-side beat position and output-side beat count
  logic [15:0]   pix_cnt;
  logic [GW-1:0] grp_cnt;
  logic          acc_all;
  logic [TW-1:0] out_cnt;

  logic [PW-1:0] prm_tab [MAX_GRP];

  logic          s1_valid, s2_valid, s3_valid;
  logic [DW-1:0] s1_dat, s1_res, s3_dat;
  logic [PW-1:0] s1_prm;
  logic [TOUT*SW-1:0] s2_sum;

  logic [TOUT*SW-1:0] sum_c;
  logic [DW-1:0]      res_c;

  logic adv, in_fire, out_fire, last_out;

  // every stage moves together; a stalled output freezes the whole pipe
  assign adv          = !s3_valid || bus.out_ready;
  assign bus.in_ready = (state == RUN) && !acc_all && adv;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = s3_valid && bus.out_ready;
  assign last_out     = (out_cnt == total_r - TW'(1));
  assign bus.out_valid = s3_valid;
  assign bus.out_dat   = s3_dat;
  assign busy          = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (out_fire && last_out) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_r   <= '0;
      grp_r   <= '0;
      total_r <= '0;
      bn_r    <= 1'b0;
      res_r   <= 1'b0;
      relu_r  <= 1'b0;
      bsh_r   <= '0;
      rsh_r   <= '0;
      osh_r   <= '0;
      pix_cnt <= '0;
      grp_cnt <= '0;
      acc_all <= 1'b0;
      out_cnt <= '0;
      done    <= 1'b0;
      prm_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (prm_we && state == RUN) prm_err <= 1'b1;
      if (state == IDLE) begin
        if (start) begin
          pix_r   <= cfg_pix;
          grp_r   <= cfg_grp;
          total_r <= TW'(cfg_pix) * TW'(cfg_grp);
          bn_r    <= cfg_bn_en;
          res_r   <= cfg_res_en;
          relu_r  <= cfg_relu_en;
          bsh_r   <= cfg_bias_sh;
          rsh_r   <= cfg_res_sh;
          osh_r   <= cfg_out_sh;
          pix_cnt <= '0;
          grp_cnt <= '0;
          acc_all <= 1'b0;
          out_cnt <= '0;
        end
      end else begin
        if (in_fire) begin
          if (pix_cnt == pix_r - 16'd1) begin
            pix_cnt <= '0;
            // grp_cnt stays on the last group so the table index stays in range
            if (grp_cnt == grp_r - GW'(1)) acc_all <= 1'b1;
            else                           grp_cnt <= grp_cnt + GW'(1);
          end else begin
            pix_cnt <= pix_cnt + 16'd1;
          end
        end
        if (out_fire) begin
          out_cnt <= out_cnt + TW'(1);
          if (last_out) done <= 1'b1;
        end
      end
    end
  end

  // table contents survive reset; writes only land while idle
  always_ff @(posedge clk) begin
    if (prm_we && state == IDLE) prm_tab[prm_addr] <= prm_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_dat   <= '0;
      s1_res   <= '0;
      s1_prm   <= '0;
      s2_sum   <= '0;
      s3_dat   <= '0;
    end else if (adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_dat <= bus.in_dat;
        s1_res <= bus.in_res;
        s1_prm <= prm_tab[grp_cnt[AW-1:0]];
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_sum <= sum_c;
      s3_valid <= s2_valid;
      if (s2_valid) s3_dat <= res_c;
    end
  end

  logic signed [DAT_DW-1:0] xs, rs;
  logic signed [BN_DW-1:0]  ws, bs;
  logic signed [SW-1:0]     xe, re, we, be;

  always_comb begin
    sum_c = '0;
    xs = '0; rs = '0; ws = '0; bs = '0;
    xe = '0; re = '0; we = '0; be = '0;
    for (int unsigned c = 0; c < TOUT; c++) begin
      xs = s1_dat[c*DAT_DW +: DAT_DW];
      rs = s1_res[c*DAT_DW +: DAT_DW];
      ws = s1_prm[c*2*BN_DW +: BN_DW];
      bs = s1_prm[c*2*BN_DW+BN_DW +: BN_DW];
      xe = SW'(xs);
      re = res_r ? SW'(rs) : '0;
      we = bn_r ? SW'(ws) : SW'(1);
      be = bn_r ? SW'(bs) : '0;
      sum_c[c*SW +: SW] = (xe * we) + (be <<< bsh_r) + (re <<< rsh_r);
    end
  end

  logic signed [SW-1:0] sv, rnd, tv, qv;

  always_comb begin
    res_c = '0;
    sv = '0; rnd = '0; tv = '0; qv = '0;
    for (int unsigned c = 0; c < TOUT; c++) begin
      sv  = $signed(s2_sum[c*SW +: SW]);
      rnd = (osh_r != 5'd0) ? (SW'(1) <<< (osh_r - 5'd1)) : '0;
      tv  = sv + rnd;
      qv  = tv >>> osh_r;
      if (relu_r && qv[SW-1]) qv = '0;
      if (qv > SAT_MAX)      qv = SAT_MAX;
      else if (qv < SAT_MIN) qv = SAT_MIN;
      res_c[c*DAT_DW +: DAT_DW] = qv[DAT_DW-1:0];
    end
  end

endmodule

// File: tb/tb_fc_bn_res_relu_pipe.sv
module tb_fc_bn_res_relu_pipe;
  localparam int TOUT    = 2;
  localparam int DAT_DW  = 16;
  localparam int BN_DW   = 16;
  localparam int MAX_GRP = 4;
  localparam int AW      = $clog2(MAX_GRP);
  localparam int GW      = AW + 1;
  localparam int DW      = TOUT * DAT_DW;
  localparam int PW      = TOUT * 2 * BN_DW;

  logic clk = 1'b0;
  logic rst, start;
  logic [15:0]   cfg_pix;
  logic [GW-1:0] cfg_grp;
  logic cfg_bn_en, cfg_res_en, cfg_relu_en;
  logic [4:0] cfg_bias_sh, cfg_res_sh, cfg_out_sh;
  logic prm_we;
  logic [AW-1:0] prm_addr;
  logic [PW-1:0] prm_wdata;
  logic busy, done, prm_err;

  fc_bn_res_relu_pipe_if #(.TOUT(TOUT), .DAT_DW(DAT_DW)) bus ();

  fc_bn_res_relu_pipe #(.TOUT(TOUT), .DAT_DW(DAT_DW), .BN_DW(BN_DW), .MAX_GRP(MAX_GRP)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_pix(cfg_pix), .cfg_grp(cfg_grp),
    .cfg_bn_en(cfg_bn_en), .cfg_res_en(cfg_res_en), .cfg_relu_en(cfg_relu_en),
    .cfg_bias_sh(cfg_bias_sh), .cfg_res_sh(cfg_res_sh), .cfg_out_sh(cfg_out_sh),
    .prm_we(prm_we), .prm_addr(prm_addr), .prm_wdata(prm_wdata),
    .bus(bus),
    .busy(busy), .done(done), .prm_err(prm_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PW-1:0] mtab [MAX_GRP];
  logic [DW-1:0] sx[$], sr[$];
  logic [DW-1:0] last_out;
  logic c_bn, c_res, c_relu;
  logic [4:0] c_bsh, c_rsh, c_osh;
  logic pend_we;
  logic [AW-1:0] pend_addr;
  logic [PW-1:0] pend_data;

  typedef struct {
    logic signed [15:0] x, r, w, b;
    logic bn, res, relu;
    logic [4:0] bsh, rsh, osh;
    logic signed [15:0] exp;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // reference: plain integer arithmetic on 64-bit values
  function automatic logic [DAT_DW-1:0] mdl(input logic signed [DAT_DW-1:0] x, r,
                                            input logic signed [BN_DW-1:0] w, b);
    longint wv, bv, s, q, lim;
    logic [DAT_DW-1:0] o;
    wv = c_bn ? longint'(w) : 64'sd1;
    bv = c_bn ? longint'(b) : 64'sd0;
    s = longint'(x) * wv + (bv <<< c_bsh);
    if (c_res) s = s + (longint'(r) <<< c_rsh);
    if (c_osh != 0) s = s + (64'sd1 <<< (c_osh - 1));
    q = s >>> c_osh;
    if (c_relu && q < 0) q = 0;
    lim = 64'sd1 <<< (DAT_DW - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim) q = -lim;
    o = q[DAT_DW-1:0];
    return o;
  endfunction

  function automatic logic [DW-1:0] beat_exp(input logic [DW-1:0] xb, rb, input logic [PW-1:0] pb);
    logic [DW-1:0] o;
    for (int c = 0; c < TOUT; c++)
      o[c*DAT_DW +: DAT_DW] = mdl(xb[c*DAT_DW +: DAT_DW], rb[c*DAT_DW +: DAT_DW],
                                  pb[c*2*BN_DW +: BN_DW], pb[c*2*BN_DW+BN_DW +: BN_DW]);
    return o;
  endfunction

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] v;
    for (int c = 0; c < TOUT; c++) v[c*DAT_DW +: DAT_DW] = 16'($urandom);
    return v;
  endfunction

  function automatic logic [PW-1:0] rnd_prm();
    logic [PW-1:0] v;
    for (int c = 0; c < TOUT; c++) v[c*2*BN_DW +: 2*BN_DW] = $urandom;
    return v;
  endfunction

  task automatic write_prm(input logic [AW-1:0] a, input logic [PW-1:0] d);
    @(negedge clk);
    prm_we = 1'b1; prm_addr = a; prm_wdata = d;
    mtab[a] = d;
    @(negedge clk);
    prm_we = 1'b0;
  endtask

  task automatic run_job(input int npix, input int ngrp, input bit bp,
                         input int bad_wr_at, input int abort_at, input bit chk_lat);
    logic [DW-1:0] eo[$];
    int n, sent, got, dones, fire_it, ov_it, tail, stray;
    n = npix * ngrp;
    @(negedge clk);
    cfg_pix = 16'(npix); cfg_grp = GW'(ngrp);
    cfg_bn_en = c_bn; cfg_res_en = c_res; cfg_relu_en = c_relu;
    cfg_bias_sh = c_bsh; cfg_res_sh = c_rsh; cfg_out_sh = c_osh;
    start = 1'b1;
    if (pend_we) begin
      prm_we = 1'b1; prm_addr = pend_addr; prm_wdata = pend_data;
      mtab[pend_addr] = pend_data;
      pend_we = 1'b0;
    end
    for (int i = 0; i < n; i++) eo.push_back(beat_exp(sx[i], sr[i], mtab[i / npix]));
    sent = 0; got = 0; dones = 0; fire_it = -1; ov_it = -1; tail = 0;
    for (int it = 0; it < 100 + 20 * n && tail < 4; it++) begin
      @(negedge clk);
      start = 1'b0; prm_we = 1'b0;
      if (it == bad_wr_at) begin
        prm_we = 1'b1; prm_addr = '0; prm_wdata = rnd_prm();
      end
      if (it == abort_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_prm_err", prm_err, 0);
        check("abort_no_done", dones, 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk); #1;
          if (bus.out_valid || done || busy) stray++;
        end
        check("abort_quiet", stray, 0);
        sx.delete(); sr.delete();
        return;
      end
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sent < n) begin
        bus.in_valid = 1'b1; bus.in_dat = sx[sent]; bus.in_res = sr[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (done) begin
        dones++;
        check("done_busy_low", busy, 0);
      end
      if (bus.out_valid && ov_it < 0) ov_it = it;
      if (bus.in_valid && bus.in_ready) begin
        if (fire_it < 0) fire_it = it;
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < n) check($sformatf("beat%0d", got), bus.out_dat, eo[got]);
        last_out = bus.out_dat;
        got++;
      end
      if (got >= n) tail++;
    end
    bus.in_valid = 1'b0;
    check("beats_delivered", got, n);
    check("done_count", dones, 1);
    check("busy_after", busy, 0);
    if (chk_lat) check("latency", ov_it - fire_it, 3);
    if (bad_wr_at >= 0) check("prm_err_set", prm_err, 1);
    sx.delete(); sr.delete();
  endtask

  task automatic rnd_cfg();
    c_bn = 1'($urandom); c_res = 1'($urandom); c_relu = 1'($urandom);
    c_bsh = 5'($urandom_range(0, 31)); c_rsh = 5'($urandom_range(0, 20));
    c_osh = 5'($urandom_range(0, 31));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; prm_we = 1'b0; prm_addr = '0; prm_wdata = '0;
    cfg_pix = '0; cfg_grp = '0; cfg_bn_en = 0; cfg_res_en = 0; cfg_relu_en = 0;
    cfg_bias_sh = '0; cfg_res_sh = '0; cfg_out_sh = '0;
    bus.in_valid = 1'b0; bus.in_dat = '0; bus.in_res = '0; bus.out_ready = 1'b0;
    pend_we = 1'b0; pend_addr = '0; pend_data = '0;
    for (int g = 0; g < MAX_GRP; g++) mtab[g] = '0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_prm_err", prm_err, 0);
    check("rst_out_dat", bus.out_dat, 0);
    #19;
    rst = 1'b0;

    //         x       r     w    b   bn res relu bsh rsh osh  exp
    vt[0] = '{100,     0,    3,   5,  1, 0, 0,   2,  0,  1,  160};
    vt[1] = '{100,  -400,    3,   5,  1, 1, 0,   2,  0,  1,  -40};
    vt[2] = '{100,  -400,    3,   5,  1, 1, 1,   2,  0,  1,    0};
    vt[3] = '{32767, 32767,  0,   0,  0, 1, 0,   0,  0,  0,  32767};
    vt[4] = '{-32768, -32768, 0,  0,  0, 1, 0,   0,  0,  0, -32768};
    vt[5] = '{1000,    0,   -2,  -7,  1, 0, 0,   0,  0,  2, -502};
    vt[6] = '{5,       0,    0,   1,  1, 0, 0,  31,  0, 31,    1};
    vt[7] = '{-32768,  0,   -1,   0,  1, 0, 1,   0,  0,  0, 32767};
    vt[8] = '{10,      3,    0,   0,  0, 1, 0,   0,  4,  0,   58};
    vt[9] = '{10,  12345,    0,   0,  0, 0, 0,   0,  0,  0,   10};

    // single-beat jobs; the table write shares the start cycle
    foreach (vt[i]) begin
      c_bn = vt[i].bn; c_res = vt[i].res; c_relu = vt[i].relu;
      c_bsh = vt[i].bsh; c_rsh = vt[i].rsh; c_osh = vt[i].osh;
      pend_we = 1'b1; pend_addr = '0;
      pend_data = {vt[i].b, vt[i].w, vt[i].b, vt[i].w};
      sx.push_back({vt[i].x ^ 16'h00ff, vt[i].x});
      sr.push_back({vt[i].r, vt[i].r});
      run_job(1, 1, 1'b0, -1, -1, 1'b1);
      check($sformatf("vec%0d_ch0", i), last_out[15:0], $unsigned(vt[i].exp));
    end

    // two groups with distinct weights, output backpressure
    c_bn = 1; c_res = 0; c_relu = 0; c_bsh = 0; c_rsh = 0; c_osh = 0;
    write_prm(0, {16'sd0, 16'sd2, 16'sd0, 16'sd2});
    write_prm(1, {16'sd0, -16'sd3, 16'sd0, -16'sd3});
    for (int i = 0; i < 6; i++) begin
      sx.push_back({16'(i * 7 + 3), 16'(i * 100 + 1)});
      sr.push_back('0);
    end
    run_job(3, 2, 1'b1, -1, -1, 1'b0);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int np, ng;
      rnd_cfg();
      np = $urandom_range(1, 5); ng = $urandom_range(1, MAX_GRP);
      for (int g = 0; g < MAX_GRP; g++) write_prm(AW'(g), rnd_prm());
      for (int i = 0; i < np * ng; i++) begin
        sx.push_back(rnd_beat()); sr.push_back(rnd_beat());
      end
      run_job(np, ng, 1'($urandom), -1, -1, 1'b0);
    end

    // table write while running is dropped; the next job still sees old table
    rnd_cfg();
    write_prm(0, rnd_prm());
    for (int i = 0; i < 2; i++) begin sx.push_back(rnd_beat()); sr.push_back(rnd_beat()); end
    run_job(2, 1, 1'b0, 1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin sx.push_back(rnd_beat()); sr.push_back(rnd_beat()); end
    run_job(3, 1, 1'b1, -1, -1, 1'b0);
    check("prm_err_sticky", prm_err, 1);

    // reset mid-job, then a fresh job after rewriting the table
    rnd_cfg();
    for (int i = 0; i < 8; i++) begin sx.push_back(rnd_beat()); sr.push_back(rnd_beat()); end
    run_job(4, 2, 1'b0, -1, 6, 1'b0);
    rnd_cfg();
    for (int g = 0; g < MAX_GRP; g++) write_prm(AW'(g), rnd_prm());
    for (int i = 0; i < 6; i++) begin sx.push_back(rnd_beat()); sr.push_back(rnd_beat()); end
    run_job(3, 2, 1'b1, -1, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
